// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared types for the execute-stage ALU: the 3-bit operation
//               encoding and the packed status-flag record.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Operation select encodings as presented on ALUControl.
    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_NOT = 3'b010,
        ALU_SLL = 3'b011,
        ALU_SRL = 3'b100,
        ALU_AND = 3'b101,
        ALU_OR  = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_t;

    // Status flags: carry/borrow, signed overflow, negative, zero.
    typedef struct packed {
        logic c;
        logic v;
        logic n;
        logic z;
    } alu_flags_t;

    localparam alu_flags_t c_flags_clear = '0;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_shifter.sv
`default_nettype none
// ============================================================================
// Module      : alu_shifter
// Description : Combinational logical shifter (left or right, zero fill).
//               The whole shift-amount word is honoured: any amount of WIDTH
//               or more shifts every bit out and yields zero.
// Ports       : i_a        - value to shift
//               i_shamt    - shift amount (full WIDTH bits)
//               i_right    - 1 = logical right, 0 = logical left
//               o_result   - shifted value
// Revision    : 1.0 - initial release
// ============================================================================
module alu_shifter #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_shamt,
    input  logic             i_right,
    output logic [WIDTH-1:0] o_result
);

    localparam logic [WIDTH-1:0] c_max_shamt = WIDTH'(WIDTH - 1);

    logic w_oversize;

    // Saturation is explicit so the result never depends on how a tool
    // treats shift amounts wider than the operand.
    assign w_oversize = (i_shamt > c_max_shamt);

    always_comb begin
        o_result = '0;
        if (!w_oversize) begin
            if (i_right) begin
                o_result = i_a >> i_shamt;
            end else begin
                o_result = i_a << i_shamt;
            end
        end
    end

endmodule : alu_shifter
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module      : alu
// Description : Integer ALU for the execute stage. ALUResult and zero are
//               combinational from a, b and ALUControl; a four-bit status
//               flag bank (c, v, n, z) captures the current operation's
//               flags on each rising clk while flag_en is high.
// Ports       : clk        - clock for the flag bank
//               reset      - asynchronous active-high clear of the flags
//               a, b       - operands (b is the shift amount for shifts)
//               ALUControl - operation select (see alu_pkg::alu_op_t)
//               flag_en    - load enable for the flag bank
//               ALUResult  - combinational result
//               zero       - combinational ALUResult == 0
//               flag_c/v/n/z - registered carry, overflow, negative, zero
// Revision    : 1.0 - initial release
// ============================================================================
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       ALUControl,
    input  logic             flag_en,
    output logic [WIDTH-1:0] ALUResult,
    output logic             zero,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_n,
    output logic             flag_z
);

    localparam int c_msb = WIDTH - 1;

    logic             w_sub;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_sum_ext;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_ovf_add;
    logic             w_ovf_sub;
    logic             w_lt;
    logic             w_shift_right;
    logic [WIDTH-1:0] w_shift;
    logic [WIDTH-1:0] w_result;
    alu_flags_t       w_next;
    alu_flags_t       r_flags;

    // SUB and SLT share the adder in subtract mode (b inverted, carry-in 1).
    // Anything else, including unknown select values, keeps it adding.
    always_comb begin
        w_sub = 1'b0;
        case (ALUControl)
            ALU_SUB, ALU_SLT: w_sub = 1'b1;
            default:          w_sub = 1'b0;
        endcase
    end

    assign w_b_eff   = b ^ {WIDTH{w_sub}};
    assign w_sum_ext = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_sub};
    assign w_sum     = w_sum_ext[WIDTH-1:0];
    assign w_cout    = w_sum_ext[WIDTH];

    assign w_ovf_add = (a[c_msb] == b[c_msb]) && (w_sum[c_msb] != a[c_msb]);
    assign w_ovf_sub = (a[c_msb] != b[c_msb]) && (w_sum[c_msb] != a[c_msb]);

    // Signed less-than from the difference: its sign, corrected when the
    // subtraction overflowed.
    assign w_lt = w_sum[c_msb] ^ w_ovf_sub;

    assign w_shift_right = (ALUControl == ALU_SRL);

    alu_shifter #(
        .WIDTH (WIDTH)
    ) u_shifter (
        .i_a      (a),
        .i_shamt  (b),
        .i_right  (w_shift_right),
        .o_result (w_shift)
    );

    always_comb begin
        w_result = w_sum;
        w_next   = c_flags_clear;
        case (ALUControl)
            ALU_SUB: begin
                w_result = w_sum;
                w_next.c = ~w_cout;      // carry-out low means a borrow
                w_next.v = w_ovf_sub;
            end
            ALU_NOT: w_result = ~a;
            ALU_SLL: w_result = w_shift;
            ALU_SRL: w_result = w_shift;
            ALU_AND: w_result = a & b;
            ALU_OR:  w_result = a | b;
            ALU_SLT: w_result = {{(WIDTH-1){1'b0}}, w_lt};
            default: begin               // ADD and any unknown select
                w_result = w_sum;
                w_next.c = w_cout;
                w_next.v = w_ovf_add;
            end
        endcase
        w_next.n = w_result[c_msb];
        w_next.z = (w_result == '0);
    end

    assign ALUResult = w_result;
    assign zero      = (w_result == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flags <= c_flags_clear;
        end else if (flag_en) begin
            r_flags <= w_next;
        end
    end

    assign flag_c = r_flags.c;
    assign flag_v = r_flags.v;
    assign flag_n = r_flags.n;
    assign flag_z = r_flags.z;

endmodule : alu
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu
// Description : Scoreboard bench for alu. Each issued vector pushes the
//               reference-model expectation (result, zero, and the flags that
//               must be visible during that cycle); a monitor on the falling
//               edge pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu;

    localparam int WIDTH = 16;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       ALUControl;
    logic             flag_en;
    logic [WIDTH-1:0] ALUResult;
    logic             zero;
    logic             flag_c;
    logic             flag_v;
    logic             flag_n;
    logic             flag_z;

    alu #(
        .WIDTH (WIDTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .a          (a),
        .b          (b),
        .ALUControl (ALUControl),
        .flag_en    (flag_en),
        .ALUResult  (ALUResult),
        .zero       (zero),
        .flag_c     (flag_c),
        .flag_v     (flag_v),
        .flag_n     (flag_n),
        .flag_z     (flag_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] res;
        logic        z;
        logic [3:0]  flags;   // {c, v, n, z}
        int          idx;
    } exp_t;

    exp_t        sb[$];
    int          vectors_applied = 0;
    int          miscompares     = 0;
    int          issued          = 0;
    logic [3:0]  model_flags     = 4'b0000;

    // Reference model in plain integer arithmetic.
    function automatic void ref_op(input logic [15:0] va, input logic [15:0] vb,
                                   input logic [2:0] op, output logic [15:0] res,
                                   output logic c, output logic v);
        longint ua;
        longint ub;
        longint sa;
        longint sbv;
        longint t;
        ua  = longint'(va);
        ub  = longint'(vb);
        sa  = longint'($signed(va));
        sbv = longint'($signed(vb));
        c   = 1'b0;
        v   = 1'b0;
        t   = 0;
        case (op)
            3'd1: begin
                t = ua - ub;
                c = (ua < ub);
                v = ((sa - sbv) > 32767) || ((sa - sbv) < -32768);
            end
            3'd2: t = longint'(~va);
            3'd3: t = (ub >= 16) ? 0 : (ua << ub);
            3'd4: t = (ub >= 16) ? 0 : (ua >> ub);
            3'd5: t = longint'(va & vb);
            3'd6: t = longint'(va | vb);
            3'd7: t = (sa < sbv) ? 1 : 0;
            default: begin
                t = ua + ub;
                c = (t > 65535);
                v = ((sa + sbv) > 32767) || ((sa + sbv) < -32768);
            end
        endcase
        res = t[15:0];
    endfunction

    // Drive one vector between clock edges and queue its expectation.
    task automatic issue(input logic [15:0] va, input logic [15:0] vb,
                         input logic [2:0] op, input logic en, input logic rst);
        exp_t        e;
        logic [15:0] r;
        logic        c;
        logic        v;
        @(posedge clk);
        #1;
        a          = va;
        b          = vb;
        ALUControl = op;
        flag_en    = en;
        reset      = rst;
        ref_op(va, vb, op, r, c, v);
        if (rst) model_flags = 4'b0000;
        e.res   = r;
        e.z     = (r == 16'h0000);
        e.flags = model_flags;
        e.idx   = issued;
        sb.push_back(e);
        issued++;
        if (!rst && en) model_flags = {c, v, r[15], (r == 16'h0000)};
    endtask

    // Monitor: compare whatever the DUT presents at mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                vectors_applied++;
                if (ALUResult !== e.res) begin
                    miscompares++;
                    $display("FAIL vec%0d ALUResult: got %h expected %h", e.idx, ALUResult, e.res);
                end
                if (zero !== e.z) begin
                    miscompares++;
                    $display("FAIL vec%0d zero: got %b expected %b", e.idx, zero, e.z);
                end
                if ({flag_c, flag_v, flag_n, flag_z} !== e.flags) begin
                    miscompares++;
                    $display("FAIL vec%0d flags cvnz: got %b expected %b", e.idx,
                             {flag_c, flag_v, flag_n, flag_z}, e.flags);
                end
            end
        end
    end

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic [2:0]  rop;
        int          wait_cycles;

        reset      = 1'b1;
        a          = '0;
        b          = '0;
        ALUControl = 3'b000;
        flag_en    = 1'b0;

        // Reset state
        issue(16'h0000, 16'h0000, 3'd0, 1'b1, 1'b1);
        // Operation walk
        issue(16'h00DC, 16'h0056, 3'd0, 1'b0, 1'b0);
        issue(16'h00DC, 16'h0056, 3'd1, 1'b0, 1'b0);
        issue(16'h00DC, 16'h0056, 3'd2, 1'b0, 1'b0);
        issue(16'h00DC, 16'h0002, 3'd3, 1'b0, 1'b0);
        issue(16'h00DC, 16'h0002, 3'd4, 1'b0, 1'b0);
        issue(16'h00DC, 16'h0010, 3'd3, 1'b0, 1'b0);
        issue(16'h00DC, 16'h0010, 3'd4, 1'b0, 1'b0);
        issue(16'h00DC, 16'h0000, 3'd3, 1'b0, 1'b0);
        issue(16'h00DC, 16'hFFFF, 3'd4, 1'b0, 1'b0);
        issue(16'h00DC, 16'h0056, 3'd5, 1'b0, 1'b0);
        issue(16'h00DC, 16'h0056, 3'd6, 1'b0, 1'b0);
        issue(16'h00DC, 16'h0056, 3'd7, 1'b0, 1'b0);
        issue(16'hFFFF, 16'h0001, 3'd7, 1'b0, 1'b0);
        issue(16'h8000, 16'h7FFF, 3'd7, 1'b0, 1'b0);
        // Flag loading
        issue(16'h00FF, 16'h00FF, 3'd1, 1'b1, 1'b0);
        issue(16'h7FFF, 16'h0001, 3'd0, 1'b1, 1'b0);
        issue(16'hFFFF, 16'h0001, 3'd0, 1'b1, 1'b0);
        issue(16'h8000, 16'h0001, 3'd1, 1'b1, 1'b0);
        issue(16'h0001, 16'h0002, 3'd1, 1'b1, 1'b0);
        // Hold with changing operands
        issue(16'h1234, 16'h0003, 3'd3, 1'b0, 1'b0);
        issue(16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0);
        issue(16'hAAAA, 16'h5555, 3'd6, 1'b0, 1'b0);
        // Reset asserted mid-cycle with flags non-zero, held over an edge
        issue(16'h7FFF, 16'h0001, 3'd0, 1'b1, 1'b1);
        issue(16'h7FFF, 16'h0001, 3'd0, 1'b0, 1'b0);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            rop = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       ra = 16'h8000 ^ 16'($urandom_range(0, 3));
                1:       ra = 16'h7FFF ^ 16'($urandom_range(0, 3));
                default: ra = 16'($urandom());
            endcase
            if ((rop == 3'd3 || rop == 3'd4) && ($urandom_range(0, 3) != 0)) begin
                rb = 16'($urandom_range(0, 20));
            end else if ($urandom_range(0, 7) == 0) begin
                rb = ra;
            end else begin
                rb = 16'($urandom());
            end
            issue(ra, rb, rop, 1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0));
        end

        // Drain the scoreboard within a bounded number of cycles
        wait_cycles = 0;
        while (sb.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        if (sb.size() > 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule : tb_alu
`default_nettype wire

// File: doc/alu.md
Name: alu

Overview:
- 16-bit integer ALU used by the CPU datapath for execute-stage arithmetic, logic, shift and compare operations.
- The result and zero outputs are purely combinational from a, b and ALUControl. They are valid in the same cycle, with no clock latency.
- A registered status-flag bank (carry, overflow, negative, zero) captures the flags of the current operation on each enabled clock edge for later branch/condition logic.

Parameters:
- WIDTH, 16, operand/result width; all behaviour below is stated for 16 and must scale.

Ports:
- clk  input  1  system clock; the flag registers update on its rising edge.
- reset  input  1  asynchronous, active-high; clears the flag registers.
- a  input  WIDTH  operand A (two's complement or unsigned, per operation).
- b  input  WIDTH  operand B; the shift amount for shift operations.
- ALUControl  input  3  operation select.
- flag_en  input  1  when 1, the flag registers load on the next rising clk.
- ALUResult  output  WIDTH  combinational operation result.
- zero  output  1  combinational; 1 iff ALUResult == 0.
- flag_c  output  1  registered carry/borrow.
- flag_v  output  1  registered signed overflow.
- flag_n  output  1  registered negative (result MSB).
- flag_z  output  1  registered zero.

Behaviour:
- Operations, selected by ALUControl:
  - 000 ADD: a + b modulo 2^16.
  - 001 SUB: a - b modulo 2^16.
  - 010 NOT: ~a; b is ignored.
  - 011 SLL: a shifted left logically by b; zero fill.
  - 100 SRL: a shifted right logically by b; zero fill.
  - 101 AND: a & b.
  - 110 OR: a | b.
  - 111 SLT: 1 if signed(a) < signed(b), else 0; result is zero-extended to 16 bits.
- Default: any ALUControl value not matching a listed encoding, including X/Z in simulation, performs ADD.
- Shift amount: the full 16-bit b is used. If b >= 16, the SLL/SRL result is 0. If b == 0, the result is a.
- zero = (ALUResult == 0), combinational, for every operation.
- Carry (next_c):
  - ADD: carry out of bit 15.
  - SUB: borrow, i.e. 1 when unsigned a < b.
  - All other operations: 0.
- Overflow (next_v):
  - ADD: operands have the same sign and the result sign differs.
  - SUB: operands have different signs and the result sign differs from a.
  - All other operations: 0.
- next_n = ALUResult[15]; next_z = zero.
- Flag registers:
  - On reset assertion, flag_c, flag_v, flag_n and flag_z are all 0 immediately, independent of clk.
  - When reset is deasserted and flag_en = 1, the flags load next_* on the rising clk.
  - When flag_en = 0, the flags hold.
  - If reset is high at a clock edge, reset wins.
- Latency: ALUResult and zero have combinational latency only. Flags are visible one cycle after the operation is presented with flag_en = 1.
- No internal state besides the four flag flops. ALUResult never depends on the flags; there is no carry-in.

Decomposition:
- Shared package alu_pkg holds:
  - an enum typedef alu_op_t for the eight 3-bit encodings (ALU_ADD … ALU_SLT);
  - a typedef alu_flags_t packed struct {c, v, n, z}.
- One sub-module is natural: alu_shifter, a combinational SLL/SRL with the >= WIDTH saturation-to-zero rule.
- Add/sub is a single adder with b inverted plus carry-in 1 for SUB, shared by SUB and the SLT comparison.

Test Plan:
- a=0x00DC, b=0x0056, ALUControl undriven (X) then 000: ALUResult=0x0132, zero=0. ALUControl=001: 0x0086, zero=0. ALUControl=010: 0xFF23.
- a=0x00DC, b=0x0002, ALUControl=011: 0x0370. ALUControl=100: 0x0037. Then b=0x0010, ALUControl=011: 0x0000, zero=1.
- a=0x00DC, b=0x0056, ALUControl=101: 0x0054. ALUControl=110: 0x00DE. ALUControl=111: 0x0000, zero=1. Then a=0xFFFF (-1), b=0x0001: ALUResult=0x0001.
- a=0x00FF, b=0x00FF, ALUControl=001: ALUResult=0, zero=1. With flag_en=1, after the rising clk: flag_z=1, flag_c=0, flag_v=0, flag_n=0.
- Flags:
  - a=0x7FFF, b=0x0001, ADD, flag_en=1, clock: flag_v=1, flag_n=1, flag_c=0.
  - a=0xFFFF, b=0x0001, ADD, clock: flag_c=1, flag_z=1.
  - a=0x0001, b=0x0002, SUB, clock: flag_c=1 (borrow), flag_n=1.
- Reset/hold:
  - Assert reset between clock edges: all flags go to 0 immediately.
  - With flag_en=0 and operands changed across edges, the flags hold while ALUResult keeps tracking the inputs.
